// File: rtl/mem_stage.sv
// Memory-access stage of the RV32I pipeline: byte/half/word data RAM, branch redirect, MEM/WB register.
// Optional misaligned-access detection is enabled by defining MEM_MISALIGN_DETECT_EN.
module mem_stage #(
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  strCtrlM,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        MemtoRegM,
    input  logic        PCBranchM,
    input  logic        branchM,
    input  logic [31:0] ALUoutM,
    input  logic [31:0] PCplusImmM,
    input  logic [4:0]  rdM,
    input  logic [31:0] r2M,
    output logic        PCSrcM,
    output logic [31:0] PCTargetM,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [4:0]  rdW,
    output logic [31:0] ALUoutW,
    output logic [31:0] ReadDataW,
    output logic        misalignW
);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] wordIdx;
    logic [1:0]        byteOff;
    logic              isByte;
    logic              isHalf;
    logic              isWord;
    logic              storeEn;
    logic              misalignAcc;
    logic              regWriteNext;
    logic [3:0]        byteEn;
    logic [31:0]       storeData;
    logic [31:0]       rdWord;
    logic [31:0]       loadData;

    // Lane extraction and sign/zero extension; reserved codes fall through to a full word.
    function automatic logic [31:0] extendLoad(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    assign wordIdx = ALUoutM[ADDR_W+1:2];
    assign byteOff = ALUoutM[1:0];
    assign isByte  = (strCtrlM[1:0] == 2'b00);
    assign isHalf  = (strCtrlM[1:0] == 2'b01);
    assign isWord  = ~isByte & ~isHalf;

    assign PCSrcM    = PCBranchM & branchM;
    assign PCTargetM = PCplusImmM;

    always_comb begin
        byteEn    = 4'b0000;
        storeData = r2M;
        if (isByte) begin
            byteEn    = 4'b0001 << byteOff;
            storeData = {4{r2M[7:0]}};
        end else if (isHalf) begin
            byteEn    = byteOff[1] ? 4'b1100 : 4'b0011;
            storeData = {2{r2M[15:0]}};
        end else if (isWord) begin
            byteEn    = 4'b1111;
        end
    end

`ifdef MEM_MISALIGN_DETECT_EN
    logic misalign;
    assign misalign     = (isHalf & byteOff[0]) | (isWord & (byteOff != 2'b00));
    assign storeEn      = MemWriteM & ~misalign;
    assign misalignAcc  = misalign & (MemWriteM | MemtoRegM);
    assign regWriteNext = RegWriteM & ~(misalign & MemtoRegM);
`else
    assign storeEn      = MemWriteM;
    assign misalignAcc  = 1'b0;
    assign regWriteNext = RegWriteM;
`endif

    // Data RAM: write at the edge, so a load on the next cycle sees the new data.
    always_ff @(posedge clk) begin
        if (storeEn && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
        end
    end

    assign rdWord   = mem[wordIdx];
    assign loadData = extendLoad(strCtrlM, byteOff, rdWord);

    // MEM/WB boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            rdW       <= 5'd0;
            ALUoutW   <= 32'd0;
            ReadDataW <= 32'd0;
            misalignW <= 1'b0;
        end else begin
            RegWriteW <= regWriteNext;
            MemtoRegW <= MemtoRegM;
            rdW       <= rdM;
            ALUoutW   <= ALUoutM;
            ReadDataW <= loadData;
            misalignW <= misalignAcc;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, loads/stores per lane, wrap, redirect, misalignment.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  strCtrlM;
    logic        RegWriteM, MemWriteM, MemtoRegM, PCBranchM, branchM;
    logic [31:0] ALUoutM, PCplusImmM, r2M;
    logic [4:0]  rdM;
    logic        PCSrcM;
    logic [31:0] PCTargetM;
    logic        RegWriteW, MemtoRegW;
    logic [4:0]  rdW;
    logic [31:0] ALUoutW, ReadDataW;
    logic        misalignW;

    int checks   = 0;
    int failures = 0;

    mem_stage #(.ADDR_W(10)) dut (
        .clk(clk), .rst(rst), .strCtrlM(strCtrlM), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCBranchM(PCBranchM),
        .branchM(branchM), .ALUoutM(ALUoutM), .PCplusImmM(PCplusImmM), .rdM(rdM),
        .r2M(r2M), .PCSrcM(PCSrcM), .PCTargetM(PCTargetM), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .rdW(rdW), .ALUoutW(ALUoutW), .ReadDataW(ReadDataW),
        .misalignW(misalignW)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
        strCtrlM  = f3;
        ALUoutM   = addr;
        r2M       = data;
        MemWriteM = 1'b1;
        MemtoRegM = 1'b0;
        tick();
        MemWriteM = 1'b0;
    endtask

    task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr);
        strCtrlM  = f3;
        ALUoutM   = addr;
        MemWriteM = 1'b0;
        MemtoRegM = 1'b1;
        tick();
        MemtoRegM = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        strCtrlM = 3'b010; RegWriteM = 1'b0; MemWriteM = 1'b0; MemtoRegM = 1'b0;
        PCBranchM = 1'b0; branchM = 1'b0; ALUoutM = 32'd0; PCplusImmM = 32'd0;
        rdM = 5'd0; r2M = 32'd0;
        tick(); tick();
        checkVal("rst_regwrite", {31'd0, RegWriteW}, 32'd0);
        checkVal("rst_readdata", ReadDataW, 32'd0);
        rst = 1'b0;

        // Async reset mid-cycle
        RegWriteM = 1'b1; ALUoutM = 32'h1234; rdM = 5'd7; MemtoRegM = 1'b1;
        tick();
        checkVal("pre_rst_aluout", ALUoutW, 32'h1234);
        checkVal("pre_rst_rd", {27'd0, rdW}, 32'd7);
        checkVal("pre_rst_regwrite", {31'd0, RegWriteW}, 32'd1);
        #3 rst = 1'b1;
        #1;
        checkVal("async_rst_aluout", ALUoutW, 32'd0);
        checkVal("async_rst_ctrl", {29'd0, RegWriteW, MemtoRegW, misalignW}, 32'd0);
        checkVal("async_rst_rd", {27'd0, rdW}, 32'd0);
        tick();
        checkVal("rst_hold_aluout", ALUoutW, 32'd0);
        #3 rst = 1'b0;
        #1;
        checkVal("rst_release_aluout", ALUoutW, 32'd0);
        tick();
        checkVal("post_rst_aluout", ALUoutW, 32'h1234);
        checkVal("post_rst_regwrite", {31'd0, RegWriteW}, 32'd1);
        MemtoRegM = 1'b0;

        // Word store/load
        doStore(3'b010, 32'h40, 32'hDEADBEEF);
        doLoad(3'b010, 32'h40);
        checkVal("lw_data", ReadDataW, 32'hDEADBEEF);
        checkVal("lw_aluout", ALUoutW, 32'h40);
        checkVal("lw_memtoreg", {31'd0, MemtoRegW}, 32'd1);

        // Byte store over zero
        doStore(3'b010, 32'h40, 32'h0);
        doStore(3'b000, 32'h41, 32'h12345680);
        doLoad(3'b000, 32'h41);
        checkVal("lb_sign", ReadDataW, 32'hFFFFFF80);
        doLoad(3'b100, 32'h41);
        checkVal("lbu_zero", ReadDataW, 32'h00000080);
        doLoad(3'b010, 32'h40);
        checkVal("sb_word", ReadDataW, 32'h00008000);

        // Half store
        doStore(3'b001, 32'h42, 32'hABCD8001);
        doLoad(3'b001, 32'h42);
        checkVal("lh_sign", ReadDataW, 32'hFFFF8001);
        doLoad(3'b101, 32'h42);
        checkVal("lhu_zero", ReadDataW, 32'h00008001);
        doLoad(3'b010, 32'h40);
        checkVal("sh_word", ReadDataW, 32'h80018000);
        doLoad(3'b000, 32'h43);
        checkVal("lb_lane3", ReadDataW, 32'hFFFFFF80);
        doLoad(3'b100, 32'h42);
        checkVal("lbu_lane2", ReadDataW, 32'h00000001);
        doLoad(3'b001, 32'h40);
        checkVal("lh_lane0", ReadDataW, 32'hFFFF8000);
        doLoad(3'b111, 32'h40);
        checkVal("reserved_as_w", ReadDataW, 32'h80018000);

        // Address wrap
        doStore(3'b010, 32'h1000, 32'h11111111);
        doLoad(3'b010, 32'h0);
        checkVal("wrap", ReadDataW, 32'h11111111);

        // Store and load together: old data captured, store performed
        strCtrlM = 3'b010; ALUoutM = 32'h0; r2M = 32'h22222222;
        MemWriteM = 1'b1; MemtoRegM = 1'b1;
        tick();
        MemWriteM = 1'b0; MemtoRegM = 1'b0;
        checkVal("st_ld_old", ReadDataW, 32'h11111111);
        doLoad(3'b010, 32'h0);
        checkVal("st_ld_new", ReadDataW, 32'h22222222);

        // Store presented during reset is dropped
        doStore(3'b010, 32'h80, 32'hAAAAAAAA);
        strCtrlM = 3'b010; ALUoutM = 32'h80; r2M = 32'h55555555; MemWriteM = 1'b1;
        rst = 1'b1;
        tick();
        MemWriteM = 1'b0;
        rst = 1'b0;
        doLoad(3'b010, 32'h80);
        checkVal("rst_store_dropped", ReadDataW, 32'hAAAAAAAA);
        doLoad(3'b010, 32'h0);
        checkVal("rst_ram_kept", ReadDataW, 32'h22222222);

        // Branch redirect is combinational
        PCBranchM = 1'b1; branchM = 1'b1; PCplusImmM = 32'h100;
        #1;
        checkVal("pcsrc_taken", {31'd0, PCSrcM}, 32'd1);
        checkVal("pctarget", PCTargetM, 32'h100);
        branchM = 1'b0;
        #1;
        checkVal("pcsrc_not_taken", {31'd0, PCSrcM}, 32'd0);
        PCBranchM = 1'b0; branchM = 1'b1;
        #1;
        checkVal("pcsrc_no_branch", {31'd0, PCSrcM}, 32'd0);
        branchM = 1'b0;
        tick();

        // Misaligned address without any memory access never flags
        strCtrlM = 3'b010; ALUoutM = 32'h43; MemWriteM = 1'b0; MemtoRegM = 1'b0;
        tick();
        checkVal("no_access_no_flag", {31'd0, misalignW}, 32'd0);

        // Misaligned word store and load
        RegWriteM = 1'b1;
        doStore(3'b010, 32'h42, 32'h99999999);
`ifdef MEM_MISALIGN_DETECT_EN
        checkVal("mis_store_flag", {31'd0, misalignW}, 32'd1);
        doLoad(3'b010, 32'h40);
        checkVal("mis_store_suppressed", ReadDataW, 32'h80018000);
        checkVal("aligned_no_flag", {31'd0, misalignW}, 32'd0);
        doLoad(3'b010, 32'h41);
        checkVal("mis_load_flag", {31'd0, misalignW}, 32'd1);
        checkVal("mis_load_regwrite", {31'd0, RegWriteW}, 32'd0);
`else
        checkVal("mis_store_noflag", {31'd0, misalignW}, 32'd0);
        doLoad(3'b010, 32'h40);
        checkVal("mis_store_written", ReadDataW, 32'h99999999);
        doLoad(3'b010, 32'h41);
        checkVal("mis_load_noflag", {31'd0, misalignW}, 32'd0);
        checkVal("mis_load_regwrite", {31'd0, RegWriteW}, 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
